// File: rtl/vram_pkg.sv
// Shared constants and types for the VRAM write scheduler.
// Rectangle fills are enabled by defining VRAM_FILL_RECT_EN.
package vram_pkg;

   localparam int VRAM_SIZE = 16000;
   localparam int LINE_W    = 160;
   localparam int VRAM_AW   = 14;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } fill_state_t;

   typedef logic [7:0] pixel_t;

endpackage

// File: rtl/vram_fill_agen.sv
// Fill address generator: column/row counters and row base.
// Row stepping exists only when VRAM_FILL_RECT_EN is defined.
module vram_fill_agen
   import vram_pkg::*;
#(
   parameter int VRAM_SIZE = vram_pkg::VRAM_SIZE,
   parameter int LINE_W    = vram_pkg::LINE_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               advance,
   input  logic [VRAM_AW-1:0] base,
   input  logic [VRAM_AW-1:0] len,
   input  logic [6:0]         height,
   output logic [VRAM_AW-1:0] cur_addr,
   output logic               cur_oob,
   output logic               last
);

   localparam logic [VRAM_AW:0] LIMIT = (VRAM_AW+1)'(VRAM_SIZE);

   logic [VRAM_AW-1:0] col;
   logic [VRAM_AW-1:0] len_q;
   logic [VRAM_AW-1:0] row_base;
   logic [VRAM_AW:0]   addr_w;
   logic               row_end;

   // one spare bit so 14-bit overflow lands out of range
   assign addr_w   = {1'b0, row_base} + {1'b0, col};
   assign cur_addr = addr_w[VRAM_AW-1:0];
   assign row_end  = (col == len_q - VRAM_AW'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col   <= '0;
         len_q <= '0;
      end else if (load) begin
         col   <= '0;
         len_q <= len;
      end else if (advance) begin
         col <= row_end ? '0 : col + VRAM_AW'(1);
      end
   end

`ifdef VRAM_FILL_RECT_EN
   localparam logic [VRAM_AW:0] STRIDE = (VRAM_AW+1)'(LINE_W);

   logic [6:0]       row;
   logic [6:0]       height_q;
   logic             row_oob;
   logic [VRAM_AW:0] next_base;

   assign next_base = {1'b0, row_base} + STRIDE;
   assign last      = row_end && (row == height_q - 7'd1);
   assign cur_oob   = row_oob || (addr_w >= LIMIT);

   // row_oob is sticky: once a row starts past the end, so do all later ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row      <= '0;
         height_q <= '0;
         row_oob  <= 1'b0;
         row_base <= '0;
      end else if (load) begin
         row      <= '0;
         height_q <= height;
         row_oob  <= 1'b0;
         row_base <= base;
      end else if (advance && row_end) begin
         row      <= row + 7'd1;
         row_base <= next_base[VRAM_AW-1:0];
         if (next_base >= LIMIT) row_oob <= 1'b1;
      end
   end
`else
   logic unused_height;

   assign unused_height = ^height;
   assign last          = row_end;
   assign cur_oob       = (addr_w >= LIMIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    row_base <= '0;
      else if (load) row_base <= base;
   end
`endif

endmodule

// File: rtl/vram_wr_sched.sv
// VRAM write-port scheduler: CPU writes win, fill engine uses idle slots.
// Define VRAM_FILL_RECT_EN to honour fill_height (rectangle fills).
module vram_wr_sched
   import vram_pkg::*;
#(
   parameter int VRAM_SIZE = vram_pkg::VRAM_SIZE,
   parameter int LINE_W    = vram_pkg::LINE_W
) (
   input  logic         cpu_clk,
   input  logic         reset_n,
   input  logic         cpu_wr,
   input  logic [13:0]  cpu_addr,
   input  logic [7:0]   cpu_data,
   input  logic         fill_start,
   input  logic [13:0]  fill_base,
   input  logic [13:0]  fill_len,
   input  logic [6:0]   fill_height,
   input  logic [7:0]   fill_color,
   output logic         fill_busy,
   output logic         fill_done,
   output logic         oob_drop,
   output logic         vram_wr,
   output logic [13:0]  vram_addr,
   output logic [7:0]   vram_data
);

   localparam logic [VRAM_AW:0] LIMIT = (VRAM_AW+1)'(VRAM_SIZE);

   fill_state_t        state, state_n;
   pixel_t             color_q;
   logic               load, fill_slot, empty, cpu_oob;
   logic [VRAM_AW-1:0] cur_addr;
   logic               cur_oob, last;
   logic               wr_n, oob_n;
   logic [VRAM_AW-1:0] addr_n;
   pixel_t             data_n;

   assign cpu_oob   = ({1'b0, cpu_addr} >= LIMIT);
   assign load      = (state == IDLE) && fill_start;
   assign fill_slot = (state == RUN) && !cpu_wr;

`ifdef VRAM_FILL_RECT_EN
   assign empty = (fill_len == '0) || (fill_height == '0);
`else
   assign empty = (fill_len == '0);
`endif

   vram_fill_agen #(
      .VRAM_SIZE (VRAM_SIZE),
      .LINE_W    (LINE_W)
   ) u_agen (
      .clk      (cpu_clk),
      .rst_n    (reset_n),
      .load     (load),
      .advance  (fill_slot),
      .base     (fill_base),
      .len      (fill_len),
      .height   (fill_height),
      .cur_addr (cur_addr),
      .cur_oob  (cur_oob),
      .last     (last)
   );

   always_ff @(posedge cpu_clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (fill_start) state_n = empty ? DONE : RUN;
         RUN:     if (fill_slot && last) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // a dropped CPU write still owns the slot, so the fill waits
   always_comb begin
      wr_n   = 1'b0;
      oob_n  = 1'b0;
      addr_n = cpu_addr;
      data_n = cpu_data;
      if (cpu_wr) begin
         wr_n  = !cpu_oob;
         oob_n = cpu_oob;
      end else if (fill_slot) begin
         wr_n   = !cur_oob;
         oob_n  = cur_oob;
         addr_n = cur_addr;
         data_n = color_q;
      end
   end

   always_ff @(posedge cpu_clk or negedge reset_n) begin
      if (!reset_n) begin
         vram_wr   <= 1'b0;
         vram_addr <= '0;
         vram_data <= '0;
         oob_drop  <= 1'b0;
         fill_busy <= 1'b0;
         fill_done <= 1'b0;
         color_q   <= '0;
      end else begin
         vram_wr   <= wr_n;
         oob_drop  <= oob_n;
         fill_busy <= (state_n != IDLE);
         fill_done <= (state == DONE);
         if (wr_n) begin
            vram_addr <= addr_n;
            vram_data <= data_n;
         end
         if (load) color_q <= fill_color;
      end
   end

endmodule
